// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the fetch address, and fills the
// IF/ID register with fetched instructions, fetch faults or bubbles. After a
// fault is emitted the stage parks in HALT until a trap or redirect arrives.
module if_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    input  logic        trap_en,
    input  logic [63:0] trap_pc,
    output logic [63:0] pc_addr,
    input  logic [31:0] imem_instruction,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_exc_en,
    output logic [3:0]  id_exc_code,
    output logic [63:0] id_exc_val
);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } id_entry_t;

    state_t    state_q, state_d;
    logic [63:0] pc_q, pc_d;
    id_entry_t id_q, id_d;

    logic        fault;
    logic [3:0]  fault_code;
    logic [63:0] fault_val;
    logic        steer;   // trap or redirect this cycle

    assign pc_addr = pc_q;
    assign steer   = trap_en | redirect_en;

    // Fault detection; only meaningful while fetching, misalignment wins.
    always_comb begin
        fault      = 1'b0;
        fault_code = 4'd0;
        fault_val  = 64'd0;
        if (state_q == RUN) begin
            if (pc_q[1:0] != 2'b00) begin
                fault      = 1'b1;
                fault_code = 4'd0;
                fault_val  = pc_q;
            end else if (imem_exc_en) begin
                fault      = 1'b1;
                fault_code = imem_exc_code;
                fault_val  = imem_exc_val;
            end
        end
    end

    // Next PC: steering beats every form of hold; a fault holds the PC so the
    // faulting address stays visible until the trap vector arrives.
    always_comb begin
        pc_d = pc_q + 64'd4;
        if (trap_en)
            pc_d = trap_pc;
        else if (redirect_en)
            pc_d = redirect_pc;
        else if (stall || state_q == HALT || fault)
            pc_d = pc_q;
    end

    // RUN/HALT: enter HALT only when the fault entry is actually emitted,
    // so a stalled or squashed fault is re-evaluated instead of lost.
    always_comb begin
        state_d = state_q;
        if (steer)
            state_d = RUN;
        else if (state_q == RUN && fault && !stall && !flush)
            state_d = HALT;
    end

    // IF/ID next entry; squash overrides stall so steering never leaks a
    // wrong-path instruction into decode.
    always_comb begin
        id_d = id_q;
        if (steer || flush || (!stall && state_q == HALT)) begin
            id_d.valid    = 1'b0;
            id_d.instr    = NOP_INSTR;
            id_d.exc_en   = 1'b0;
            id_d.exc_code = 4'd0;
            id_d.exc_val  = 64'd0;
        end else if (!stall) begin
            id_d.valid    = 1'b1;
            id_d.pc       = pc_q;
            id_d.instr    = fault ? NOP_INSTR : imem_instruction;
            id_d.exc_en   = fault;
            id_d.exc_code = fault_code;
            id_d.exc_val  = fault_val;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            id_q    <= '{valid: 1'b0, pc: 64'd0, instr: NOP_INSTR,
                         exc_en: 1'b0, exc_code: 4'd0, exc_val: 64'd0};
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    assign id_valid       = id_q.valid;
    assign id_pc          = id_q.pc;
    assign id_instruction = id_q.instr;
    assign id_exc_en      = id_q.exc_en;
    assign id_exc_code    = id_q.exc_code;
    assign id_exc_val     = id_q.exc_val;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequencing, stall, redirect, faults,
// HALT behaviour, trap priority and reset out of HALT.
module tb_if_stage;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect_en, trap_en;
    logic [63:0] redirect_pc, trap_pc, pc_addr;
    logic [31:0] imem_instruction;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        id_valid, id_exc_en;
    logic [63:0] id_pc, id_exc_val;
    logic [31:0] id_instruction;
    logic [3:0]  id_exc_code;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .trap_en(trap_en), .trap_pc(trap_pc), .pc_addr(pc_addr),
        .imem_instruction(imem_instruction), .imem_exc_en(imem_exc_en),
        .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
        .id_valid(id_valid), .id_pc(id_pc), .id_instruction(id_instruction),
        .id_exc_en(id_exc_en), .id_exc_code(id_exc_code), .id_exc_val(id_exc_val)
    );

    always #5 clk = ~clk;

    // one rising edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 0; flush = 0; redirect_en = 0; trap_en = 0;
        redirect_pc = 0; trap_pc = 0; imem_instruction = 32'hFFFF_FFFF;
        imem_exc_en = 0; imem_exc_code = 0; imem_exc_val = 0;
        step(); step();
        n_checks++; if (pc_addr !== 64'h1000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_addr, 64'h1000); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        n_checks++; if (id_instruction !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", id_instruction, NOP); end
        n_checks++; if (id_pc !== 64'h0 || id_exc_en !== 1'b0 || id_exc_code !== 4'h0 || id_exc_val !== 64'h0) begin n_fail++; $display("FAIL reset_id_fields: got pc=%h exc=%b code=%h val=%h want zeros", id_pc, id_exc_en, id_exc_code, id_exc_val); end
        rst = 1'b0; imem_instruction = 32'h0050_0093;
        step();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 64'h1000 || id_instruction !== 32'h0050_0093) begin n_fail++; $display("FAIL first_fetch: got v=%b pc=%h ins=%h want 1/1000/00500093", id_valid, id_pc, id_instruction); end
        n_checks++; if (pc_addr !== 64'h1004) begin n_fail++; $display("FAIL first_pc_inc: got %h want 1004", pc_addr); end
    endtask

    task automatic test_sequential_stall();
        imem_instruction = 32'h0010_0113;
        step(); step();
        n_checks++; if (pc_addr !== 64'h100C || id_pc !== 64'h1008) begin n_fail++; $display("FAIL seq_run: got pc=%h id_pc=%h want 100c/1008", pc_addr, id_pc); end
        stall = 1'b1; imem_instruction = 32'hDEAD_BEEF;
        step(); step();
        n_checks++; if (pc_addr !== 64'h100C) begin n_fail++; $display("FAIL stall_pc_hold: got %h want 100c", pc_addr); end
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 64'h1008 || id_instruction !== 32'h0010_0113) begin n_fail++; $display("FAIL stall_id_hold: got v=%b pc=%h ins=%h want 1/1008/00100113", id_valid, id_pc, id_instruction); end
        stall = 1'b0;
        step();
        n_checks++; if (pc_addr !== 64'h1010 || id_pc !== 64'h100C || id_instruction !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_release: got pc=%h id_pc=%h ins=%h want 1010/100c/deadbeef", pc_addr, id_pc, id_instruction); end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h2000;
        step();
        stall = 1'b0; redirect_en = 1'b0;
        n_checks++; if (pc_addr !== 64'h2000) begin n_fail++; $display("FAIL redir_stall_pc: got %h want 2000", pc_addr); end
        n_checks++; if (id_valid !== 1'b0 || id_instruction !== NOP) begin n_fail++; $display("FAIL redir_stall_bubble: got v=%b ins=%h want 0/%h", id_valid, id_instruction, NOP); end
    endtask

    task automatic test_misaligned();
        redirect_en = 1'b1; redirect_pc = 64'h2002;
        step();
        redirect_en = 1'b0;
        step();
        n_checks++; if (id_valid !== 1'b1 || id_exc_en !== 1'b1 || id_exc_code !== 4'd0 || id_exc_val !== 64'h2002 || id_pc !== 64'h2002 || id_instruction !== NOP) begin n_fail++; $display("FAIL misalign_entry: got v=%b exc=%b code=%h val=%h pc=%h ins=%h want 1/1/0/2002/2002/%h", id_valid, id_exc_en, id_exc_code, id_exc_val, id_pc, id_instruction, NOP); end
        n_checks++; if (pc_addr !== 64'h2002) begin n_fail++; $display("FAIL misalign_pc_hold: got %h want 2002", pc_addr); end
        step(); step();
        n_checks++; if (id_valid !== 1'b0 || id_exc_en !== 1'b0 || pc_addr !== 64'h2002) begin n_fail++; $display("FAIL misalign_halt: got v=%b exc=%b pc=%h want 0/0/2002", id_valid, id_exc_en, pc_addr); end
    endtask

    task automatic test_access_fault_trap();
        // redirect out of HALT onto an unbacked address
        redirect_en = 1'b1; redirect_pc = 64'h4_0000;
        step();
        redirect_en = 1'b0;
        imem_exc_en = 1'b1; imem_exc_code = 4'd1; imem_exc_val = 64'h4_0000;
        step();
        n_checks++; if (id_valid !== 1'b1 || id_exc_en !== 1'b1 || id_exc_code !== 4'd1 || id_exc_val !== 64'h4_0000 || pc_addr !== 64'h4_0000) begin n_fail++; $display("FAIL access_entry: got v=%b exc=%b code=%h val=%h pc=%h want 1/1/1/40000/40000", id_valid, id_exc_en, id_exc_code, id_exc_val, pc_addr); end
        imem_exc_en = 1'b0;
        step();
        imem_exc_en = 1'b1;
        step();
        n_checks++; if (id_valid !== 1'b0 || id_exc_en !== 1'b0 || pc_addr !== 64'h4_0000) begin n_fail++; $display("FAIL access_single_entry: got v=%b exc=%b pc=%h want 0/0/40000", id_valid, id_exc_en, pc_addr); end
        imem_exc_en = 1'b0; trap_en = 1'b1; trap_pc = 64'h80;
        step();
        trap_en = 1'b0; imem_instruction = 32'h0000_0033;
        n_checks++; if (pc_addr !== 64'h80 || id_valid !== 1'b0) begin n_fail++; $display("FAIL trap_vector: got pc=%h v=%b want 80/0", pc_addr, id_valid); end
        step();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 64'h80 || id_instruction !== 32'h0000_0033 || pc_addr !== 64'h84) begin n_fail++; $display("FAIL trap_resume: got v=%b pc=%h ins=%h next=%h want 1/80/00000033/84", id_valid, id_pc, id_instruction, pc_addr); end
    endtask

    task automatic test_fault_while_stalled();
        stall = 1'b1; imem_exc_en = 1'b1; imem_exc_code = 4'd1; imem_exc_val = 64'h84;
        step();
        n_checks++; if (id_exc_en !== 1'b0 || id_pc !== 64'h80 || pc_addr !== 64'h84) begin n_fail++; $display("FAIL stalled_fault_ignored: got exc=%b id_pc=%h pc=%h want 0/80/84", id_exc_en, id_pc, pc_addr); end
        stall = 1'b0;
        step();
        imem_exc_en = 1'b0;
        n_checks++; if (id_exc_en !== 1'b1 || id_exc_val !== 64'h84 || id_pc !== 64'h84) begin n_fail++; $display("FAIL stalled_fault_release: got exc=%b val=%h pc=%h want 1/84/84", id_exc_en, id_exc_val, id_pc); end
    endtask

    task automatic test_flush();
        redirect_en = 1'b1; redirect_pc = 64'h3000;
        step();
        redirect_en = 1'b0; imem_instruction = 32'h0020_0193;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (id_valid !== 1'b0 || id_instruction !== NOP || pc_addr !== 64'h3008) begin n_fail++; $display("FAIL flush_bubble: got v=%b ins=%h pc=%h want 0/%h/3008", id_valid, id_instruction, pc_addr, NOP); end
    endtask

    task automatic test_pc_wrap();
        redirect_en = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_en = 1'b0;
        step();
        n_checks++; if (pc_addr !== 64'h0 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL pc_wrap: got pc=%h id_pc=%h want 0/fffffffffffffffc", pc_addr, id_pc); end
    endtask

    task automatic test_trap_over_redirect();
        trap_en = 1'b1; trap_pc = 64'h100; redirect_en = 1'b1; redirect_pc = 64'h200;
        step();
        trap_en = 1'b0; redirect_en = 1'b0;
        n_checks++; if (pc_addr !== 64'h100) begin n_fail++; $display("FAIL trap_priority: got %h want 100", pc_addr); end
    endtask

    task automatic test_reset_in_halt();
        redirect_en = 1'b1; redirect_pc = 64'h5001;
        step();
        redirect_en = 1'b0;
        step();
        n_checks++; if (id_exc_en !== 1'b1 || id_exc_val !== 64'h5001) begin n_fail++; $display("FAIL halt_entry: got exc=%b val=%h want 1/5001", id_exc_en, id_exc_val); end
        rst = 1'b1;
        step();
        rst = 1'b0; imem_instruction = 32'h0030_0213;
        n_checks++; if (pc_addr !== 64'h1000 || id_valid !== 1'b0 || id_exc_en !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got pc=%h v=%b exc=%b want 1000/0/0", pc_addr, id_valid, id_exc_en); end
        step();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 64'h1000 || id_instruction !== 32'h0030_0213 || pc_addr !== 64'h1004) begin n_fail++; $display("FAIL halt_reset_run: got v=%b pc=%h ins=%h next=%h want 1/1000/00300213/1004", id_valid, id_pc, id_instruction, pc_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential_stall();
        test_redirect_over_stall();
        test_misaligned();
        test_access_fault_trap();
        test_fault_while_stalled();
        test_flush();
        test_pc_wrap();
        test_trap_over_redirect();
        test_reset_in_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
